// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - registered execute stage: forwarding, ALU, iterative multiply (divide with EX_STAGE_DIV_EN)
module ex_stage_pipe #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [WIDTH-1:0]    fwd_mem,
  input  logic [WIDTH-1:0]    fwd_wb,
  input  logic [WIDTH-1:0]    imediato,
  input  logic [1:0]          sel_a,
  input  logic [1:0]          sel_b,
  input  logic                sel_imm,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [REG_BITS-1:0] rd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [REG_BITS-1:0] rd_out,
  output logic [WIDTH-1:0]    hi_out,
  output logic [WIDTH-1:0]    lo_out,
  output logic                overflow,
  output logic                illegal,
  output logic                busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic                  neg_q, neg_d;
  logic [REG_BITS-1:0]   md_rd_q, md_rd_d;
  logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic [REG_BITS-1:0]   rd_q, rd_d;
  logic                  ovf_q, ovf_d, ill_q, ill_d, valid_q, valid_d;

  logic [WIDTH-1:0]      src_a, src_b, alu_b, sum, diff;
  logic                  add_ovf, sub_ovf, slt_s, slt_u, accept;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_ovf, alu_ill, md_go, md_signed;
  logic [WIDTH:0]        mul_sum;
  logic [2*WIDTH-1:0]    mul_next, mul_final, step_next;

`ifdef EX_STAGE_DIV_EN
  logic                  md_div;
  logic                  div_q, div_d, rneg_q, rneg_d, divz_q, divz_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [WIDTH:0]        rem_sh, rem_dif;
  logic [2*WIDTH-1:0]    div_next;
`endif

  always_comb begin
    case (sel_a)
      2'b01:   src_a = fwd_mem;
      2'b10:   src_a = fwd_wb;
      default: src_a = operand_a;
    endcase
    case (sel_b)
      2'b01:   src_b = fwd_mem;
      2'b10:   src_b = fwd_wb;
      default: src_b = operand_b;
    endcase
  end

  assign alu_b   = sel_imm ? imediato : src_b;
  assign sum     = src_a + alu_b;
  assign diff    = src_a - alu_b;
  assign add_ovf = (src_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  assign sub_ovf = (src_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
  assign slt_s   = $signed(src_a) < $signed(alu_b);
  assign slt_u   = src_a < alu_b;

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    md_go     = 1'b0;
    md_signed = 1'b0;
`ifdef EX_STAGE_DIV_EN
    md_div    = 1'b0;
`endif
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin alu_res = sum;  alu_ovf = add_ovf; end
          6'h21: alu_res = sum;
          6'h22: begin alu_res = diff; alu_ovf = sub_ovf; end
          6'h23: alu_res = diff;
          6'h24: alu_res = src_a & alu_b;
          6'h25: alu_res = src_a | alu_b;
          6'h26: alu_res = src_a ^ alu_b;
          6'h27: alu_res = ~(src_a | alu_b);
          6'h2A: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
          6'h2B: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
          6'h04: alu_res = alu_b << src_a[SHW-1:0];
          6'h06: alu_res = alu_b >> src_a[SHW-1:0];
          6'h07: alu_res = $signed(alu_b) >>> src_a[SHW-1:0];
          6'h18: begin md_go = 1'b1; md_signed = 1'b1; end
          6'h19: md_go = 1'b1;
          6'h10: alu_res = hi_q;
          6'h12: alu_res = lo_q;
`ifdef EX_STAGE_DIV_EN
          6'h1A: begin md_go = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
          6'h1B: begin md_go = 1'b1; md_div = 1'b1; end
`endif
          default: alu_ill = 1'b1;
        endcase
      end
      6'h08: begin alu_res = sum; alu_ovf = add_ovf; end
      6'h09: alu_res = sum;
      6'h0A: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
      6'h0B: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
      6'h0C: alu_res = src_a & alu_b;
      6'h0D: alu_res = src_a | alu_b;
      6'h0E: alu_res = src_a ^ alu_b;
      6'h0F: alu_res = alu_b << 16;
      default: alu_ill = 1'b1;
    endcase
  end

  // Shift-add with the multiplier in the low half; the carry re-enters at the top on the shift.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_final = neg_q ? -prod_q : prod_q;

`ifdef EX_STAGE_DIV_EN
  // Restoring step: remainder in the high half, dividend/quotient shifting through the low half.
  assign rem_sh    = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign rem_dif   = rem_sh - {1'b0, mcand_q};
  assign div_next  = rem_dif[WIDTH] ? {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                    : {rem_dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign step_next = div_q ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  assign in_ready = reset && (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    md_rd_d  = md_rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    rd_d     = rd_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    valid_d  = valid_q;
`ifdef EX_STAGE_DIV_EN
    div_d    = div_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    dvd_d    = dvd_q;
`endif
    if (valid_q && out_ready) valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (md_go) begin
            state_d = S_MUL;
            cnt_d   = CW'(WIDTH);
            md_rd_d = rd_in;
            neg_d   = md_signed && (src_a[WIDTH-1] ^ alu_b[WIDTH-1]);
            mcand_d = (md_signed && alu_b[WIDTH-1]) ? -alu_b : alu_b;
            prod_d  = {{WIDTH{1'b0}}, ((md_signed && src_a[WIDTH-1]) ? -src_a : src_a)};
`ifdef EX_STAGE_DIV_EN
            div_d   = md_div;
            rneg_d  = md_signed && src_a[WIDTH-1];
            divz_d  = (alu_b == '0);
            dvd_d   = src_a;
`endif
          end else begin
            result_d = alu_ill ? '0 : alu_res;
            rd_d     = rd_in;
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          prod_d = step_next;
        end
      end
      S_DONE: begin
        if (!valid_q || out_ready) begin
`ifdef EX_STAGE_DIV_EN
          if (!div_q) begin
            {hi_d, lo_d} = mul_final;
          end else if (divz_q) begin
            lo_d = '1;
            hi_d = dvd_q;
          end else begin
            lo_d = neg_q  ? -prod_q[WIDTH-1:0]       : prod_q[WIDTH-1:0];
            hi_d = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
          end
`else
          {hi_d, lo_d} = mul_final;
`endif
          result_d = lo_d;
          rd_d     = md_rd_q;
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      md_rd_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      md_rd_q  <= md_rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

`ifdef EX_STAGE_DIV_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= 1'b0;
      rneg_q <= 1'b0;
      divz_q <= 1'b0;
      dvd_q  <= '0;
    end else begin
      div_q  <= div_d;
      rneg_q <= rneg_d;
      divz_q <= divz_d;
      dvd_q  <= dvd_d;
    end
  end
`endif

  assign out_valid = valid_q;
  assign result    = result_q;
  assign rd_out    = rd_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
  assign busy      = (state_q == S_MUL);

endmodule
